dvp_tx: RTL and testbench

DVP_TX -- requirements
Module: dvp_tx

---
 rtl/dvp_pkg.sv | 36 +++
 rtl/dvp_tx_pattern.sv | 19 +
 rtl/dvp_tx.sv | 141 ++++++++++++++
 tb/tb_dvp_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_pkg.sv
// dvp_pkg: shared state encoding, RGB565 colour-bar constants and default DVP timing
// Ports: none (package); bar_color() maps a bar index 0..7 to its RGB565 colour.
package dvp_pkg;

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} dvp_state_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_BLANK  = 144;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BPORCH = 17;
    localparam int DEF_V_FPORCH = 10;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/dvp_tx_pattern.sv
// dvp_tx_pattern: eight vertical colour bars selected by horizontal pixel index
// Ports: pix_idx_i pixel index within the line; rgb_o RGB565 colour of that pixel's bar.
module dvp_tx_pattern
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic [10:0] pix_idx_i,
    output logic [15:0] rgb_o
);
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [10:0] bar;

    assign bar   = pix_idx_i / 11'(BAR_W);
    // Pixels past the eighth bar (H_ACTIVE not a multiple of 8) stay on the last bar
    assign rgb_o = bar_color(bar > 11'd7 ? 3'd7 : bar[2:0]);

endmodule

// File: rtl/dvp_tx.sv
// dvp_tx: OV7670-style DVP transmitter sending RGB565 pixels as byte pairs with vsync/href framing
// Ports: clk, rst_n (async active-low); enable requests frames; pix_data/pix_valid/pix_ready
//        pixel handshake; test_mode selects colour bars; cam_pclk/cam_vsync/cam_href/cam_data
//        DVP bus; frame_done one-clk end-of-frame pulse; underrun sticky starvation flag.
// Build option: define DVP_TX_TEST_PATTERN_EN to include the colour-bar generator.
module dvp_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BPORCH = DEF_V_BPORCH,
    parameter int V_FPORCH = DEF_V_FPORCH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        test_mode,
    output logic        cam_pclk,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic        underrun
);
    localparam logic [10:0] H_LAST      = 11'(2 * H_ACTIVE + H_BLANK - 1);
    localparam logic [10:0] H_ACT_SLOTS = 11'(2 * H_ACTIVE);
    localparam logic [9:0]  V_SYNC_END  = 10'(V_SYNC - 1);
    localparam logic [9:0]  V_BACK_END  = 10'(V_SYNC + V_BPORCH - 1);
    localparam logic [9:0]  V_ACT_END   = 10'(V_SYNC + V_BPORCH + V_ACTIVE - 1);
    localparam logic [9:0]  V_LAST      = 10'(V_SYNC + V_BPORCH + V_ACTIVE + V_FPORCH - 1);

    dvp_state_e  state_q, state_d;
    logic        phase_q;
    logic [10:0] h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic [7:0]  data_q, lo_q;
    logic        frame_done_q, underrun_q;
    logic        line_end, frame_end, nxt_act, nxt_even, use_pat, src_ok;
    logic [15:0] src;

    // Next slot position; only committed on the edge that closes phase 1
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        v_d       = v_q;
        frame_end = 1'b0;
        line_end  = (h_q == H_LAST);
        if (state_q == IDLE) begin
            if (enable) state_d = VSYNC;
        end else begin
            h_d = line_end ? 11'd0 : h_q + 11'd1;
            if (line_end) begin
                v_d = v_q + 10'd1;
                case (state_q)
                    VSYNC:   if (v_q == V_SYNC_END) state_d = VBACK;
                    VBACK:   if (v_q == V_BACK_END) state_d = ACTIVE;
                    ACTIVE:  if (v_q == V_ACT_END) state_d = VFRONT;
                    VFRONT:  if (v_q == V_LAST) begin
                        v_d       = 10'd0;
                        frame_end = 1'b1;
                        state_d   = enable ? VSYNC : IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    assign nxt_act  = (state_d == ACTIVE) && (h_d < H_ACT_SLOTS);
    assign nxt_even = nxt_act && !h_d[0];

`ifdef DVP_TX_TEST_PATTERN_EN
    logic        tm_q;
    logic [15:0] pat;

    dvp_tx_pattern #(.H_ACTIVE(H_ACTIVE)) u_pattern (
        .pix_idx_i ({1'b0, h_d[10:1]}),
        .rgb_o     (pat)
    );

    // Pattern choice is frozen for the whole frame at VSYNC entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tm_q <= 1'b0;
        else if (phase_q && state_d == VSYNC && state_q != VSYNC) tm_q <= test_mode;
    end

    assign use_pat = tm_q;
    assign src     = tm_q ? pat : pix_data;
`else
    logic unused_test_mode;

    assign unused_test_mode = test_mode;
    assign use_pat          = 1'b0;
    assign src              = pix_data;
`endif

    assign src_ok    = use_pat || pix_valid;
    // Handshake sits in phase 1 so the high byte lands on the edge opening the even slot
    assign pix_ready = phase_q && nxt_even && !use_pat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= 1'b0;
            state_q      <= IDLE;
            h_q          <= '0;
            v_q          <= '0;
            data_q       <= '0;
            lo_q         <= '0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            phase_q      <= ~phase_q;
            frame_done_q <= phase_q && frame_end;
            if (phase_q) begin
                state_q <= state_d;
                h_q     <= h_d;
                v_q     <= v_d;
                if (nxt_even) begin
                    data_q <= src_ok ? src[15:8] : 8'h00;
                    lo_q   <= src_ok ? src[7:0] : 8'h00;
                end else begin
                    data_q <= nxt_act ? lo_q : 8'h00;
                end
                if (pix_ready && !pix_valid) underrun_q <= 1'b1;
            end
        end
    end

    assign cam_pclk   = phase_q;
    assign cam_vsync  = (state_q == VSYNC);
    assign cam_href   = (state_q == ACTIVE) && (h_q < H_ACT_SLOTS);
    assign cam_data   = data_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_dvp_tx.sv
// tb_dvp_tx: table-driven scoreboard bench for dvp_tx with small timing parameters
module tb_dvp_tx;

    typedef struct {
        logic [15:0] pix;
        logic        valid;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;

    logic        clk, rst_n, enable, pix_valid, test_mode;
    logic [15:0] pix_data;
    logic        pix_ready, cam_pclk, cam_vsync, cam_href, frame_done, underrun;
    logic [7:0]  cam_data;

    vec_t        tbl[16];
    logic [7:0]  sbq[$];
    int          n_chk, n_fail, cyc, idx;
    bit          sb_on;

    dvp_tx #(
        .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(2), .V_SYNC(1), .V_BPORCH(1), .V_FPORCH(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .test_mode(test_mode),
        .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .frame_done(frame_done), .underrun(underrun)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Driver: offers the next table pixel whenever the DUT asks, and records the bytes it must emit
    initial begin
        pix_valid = 0;
        pix_data  = 0;
        forever begin
            @(negedge clk);
            if (sb_on && pix_ready) begin
                pix_data  = tbl[idx % 16].pix;
                pix_valid = tbl[idx % 16].valid;
                sbq.push_back(tbl[idx % 16].hi);
                sbq.push_back(tbl[idx % 16].lo);
                idx++;
            end else begin
                pix_valid = 0;
            end
        end
    end

    // Monitor: one byte per slot, sampled in phase 0 well away from the clk edge
    initial forever begin
        @(negedge clk);
        if (sb_on) begin
            if (cam_href && !cam_pclk) begin
                check("sb_nonempty", sbq.size() != 0, 1);
                if (sbq.size() != 0) check("byte", cam_data, sbq.pop_front());
            end else if (!cam_href) begin
                check("data_zero_href_low", cam_data, 0);
            end
        end
    end

`ifdef DVP_TX_TEST_PATTERN_EN
    logic       p_ready, p_pclk, p_vs, p_href, p_fd, p_ur, p_tm;
    logic [7:0] p_data;
    logic [7:0] p_bytes[$];
    int         p_ready_hits;

    dvp_tx #(
        .H_ACTIVE(8), .H_BLANK(2), .V_ACTIVE(2), .V_SYNC(1), .V_BPORCH(1), .V_FPORCH(1)
    ) dut_p (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pix_data(16'h1234),
        .pix_valid(1'b0), .pix_ready(p_ready), .test_mode(p_tm),
        .cam_pclk(p_pclk), .cam_vsync(p_vs), .cam_href(p_href),
        .cam_data(p_data), .frame_done(p_fd), .underrun(p_ur)
    );

    initial begin
        p_tm = 1;
        forever begin
            @(negedge clk);
            if (p_ready) p_ready_hits++;
            if (p_href && !p_pclk && p_bytes.size() < 16) p_bytes.push_back(p_data);
        end
    end
`endif

    task automatic wait_hi(input string nm, input bit use_href);
        int n = 0;
        while (n < 300 && !(use_href ? cam_href : cam_vsync)) begin
            @(negedge clk);
            n++;
        end
        check(nm, use_href ? cam_href : cam_vsync, 1);
    endtask

    task automatic count_lvl(input bit use_href, input bit lvl, output int c);
        c = 0;
        while ((use_href ? cam_href : cam_vsync) == lvl && c < 300) begin
            c++;
            @(negedge clk);
        end
    endtask

    task automatic wait_fd(output int t);
        int n = 0;
        t = -1;
        while (n < 300 && t < 0) begin
            @(negedge clk);
            n++;
            if (frame_done) t = cyc;
        end
        check("frame_done_seen", t >= 0, 1);
    endtask

    initial begin
        int c, t0, t1, t2, hits;
        tbl[0]  = '{16'hA1B2, 1'b1, 8'hA1, 8'hB2};
        tbl[1]  = '{16'hC3D4, 1'b1, 8'hC3, 8'hD4};
        tbl[2]  = '{16'hE5F6, 1'b1, 8'hE5, 8'hF6};
        tbl[3]  = '{16'h0718, 1'b1, 8'h07, 8'h18};
        tbl[4]  = '{16'h1122, 1'b1, 8'h11, 8'h22};
        tbl[5]  = '{16'h3344, 1'b1, 8'h33, 8'h44};
        tbl[6]  = '{16'h5566, 1'b1, 8'h55, 8'h66};
        tbl[7]  = '{16'h7788, 1'b1, 8'h77, 8'h88};
        tbl[8]  = '{16'hA1B2, 1'b1, 8'hA1, 8'hB2};
        tbl[9]  = '{16'hC3D4, 1'b1, 8'hC3, 8'hD4};
        tbl[10] = '{16'hE5F6, 1'b0, 8'h00, 8'h00};
        tbl[11] = '{16'h0718, 1'b1, 8'h07, 8'h18};
        tbl[12] = '{16'h9ABC, 1'b1, 8'h9A, 8'hBC};
        tbl[13] = '{16'hDEF0, 1'b1, 8'hDE, 8'hF0};
        tbl[14] = '{16'h1357, 1'b1, 8'h13, 8'h57};
        tbl[15] = '{16'h2468, 1'b1, 8'h24, 8'h68};

        rst_n = 0;
        enable = 0;
        test_mode = 0;
        #23;
        check("rst_pclk", cam_pclk, 0);
        check("rst_vsync", cam_vsync, 0);
        check("rst_href", cam_href, 0);
        check("rst_data", cam_data, 0);
        check("rst_ready", pix_ready, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_underrun", underrun, 0);

        @(negedge clk);
        sb_on = 1;
        enable = 1;
        rst_n = 1;

        wait_hi("vsync_rise", 0);
        count_lvl(0, 1, c);
        check("vsync_width_clk", c, 20);
        wait_hi("href_rise", 1);
        count_lvl(1, 1, c);
        check("href_high_clk", c, 16);
        count_lvl(1, 0, c);
        check("href_low_clk", c, 4);

        wait_fd(t0);
        check("underrun_clean_frame", underrun, 0);
        @(negedge clk);
        check("frame_done_width", frame_done, 0);

        wait_fd(t1);
        check("frame_period", t1 - t0, 100);
        check("underrun_set", underrun, 1);

        wait_hi("href_frame2", 1);
        enable = 0;
        wait_fd(t2);
        check("frame_completes_after_drop", t2 - t1, 100);
        check("underrun_sticky", underrun, 1);
        hits = 0;
        repeat (150) begin
            @(negedge clk);
            if (cam_vsync || cam_href || frame_done || pix_ready) hits++;
        end
        check("idle_quiet", hits, 0);

        enable = 1;
        wait_hi("href_before_reset", 1);
        repeat (3) @(negedge clk);
        sb_on = 0;
        #2 rst_n = 0;
        #1;
        check("async_reset_outs",
              {cam_pclk, cam_vsync, cam_href, cam_data, pix_ready, frame_done, underrun}, 0);
        sbq.delete();
        idx = 0;
        repeat (5) @(negedge clk);
        check("reset_hold_outs", {cam_pclk, cam_href, cam_data, frame_done}, 0);
        sb_on = 1;
        rst_n = 1;
        hits = 0;
        repeat (50) begin
            @(negedge clk);
            if (frame_done) hits++;
        end
        check("no_fd_after_reset", hits, 0);
        wait_fd(t0);
        check("post_reset_pixels", idx, 8);
        check("post_reset_sb_drained", sbq.size(), 0);
        check("post_reset_underrun", underrun, 0);

`ifdef DVP_TX_TEST_PATTERN_EN
        begin
            logic [7:0] exp_p[16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                      8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
            check("pat_byte_count", p_bytes.size(), 16);
            for (int i = 0; i < 16 && i < p_bytes.size(); i++) check("pat_byte", p_bytes[i], exp_p[i]);
            check("pat_ready_never", p_ready_hits, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
